tsu_queue_reader: RTL

Read-side drain engine for the PTP time-stamp queue. It sits in the q_rd_clk domain. It pops 48-bit entries from the time-stamp dcfifo, presents one entry at a time to the host register block in a holding register with a valid/ack handshake, and raises an interrupt on a fill threshold. It also provides a flush sequencer and pop/drop statistics.

---
 rtl/tsu_queue_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/tsu_queue_reader.sv
// Drains the PTP time-stamp queue into a host-visible holding register with valid/ack, flush and stats.
// Pop-to-valid takes 1+RD_LAT cycles; no new pop is issued while ts_valid is held, so the host ack is the backpressure.
module tsu_queue_reader #(
  parameter int RD_LAT     = 1,
  parameter int IRQ_THRESH = 1
) (
  input  logic        q_rd_clk,
  input  logic        rst,
  output logic        q_rd_en,
  input  logic [7:0]  q_rd_stat,
  input  logic [47:0] q_rd_data,
  input  logic        ts_ack,
  input  logic        ts_flush,
  output logic        ts_valid,
  output logic [47:0] ts_data,
  output logic [7:0]  ts_pending,
  output logic        ts_irq,
  output logic        ts_flush_busy,
  output logic [15:0] ts_pop_cnt,
  output logic [7:0]  ts_drop_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, LOAD, HOLD, FLUSH} state_t;

  localparam logic [1:0] WAIT_LAST = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

  state_t      state, state_nxt;
  logic [1:0]  wait_cnt;
  logic        flush_pend;
  logic [3:0]  q_cnt;
  logic        drop_word;
  logic        unused_stat;

  logic        q_rd_en_nxt, valid_nxt, pend_nxt, busy_nxt, irq_nxt, drop_inc;
  logic [47:0] data_nxt;
  logic [15:0] pop_nxt;
  logic [7:0]  drop_nxt, pending_nxt;

  assign q_cnt       = q_rd_stat[3:0];
  assign unused_stat = ^q_rd_stat[7:4];
  // A word read while any flush is pending or running is discarded, never held.
  assign drop_word   = flush_pend | ts_flush_busy | ts_flush;

  always_ff @(posedge q_rd_clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ts_flush || flush_pend) state_nxt = FLUSH;
        else if (q_cnt != 4'd0)     state_nxt = REQ;
      end
      REQ:   state_nxt = (RD_LAT <= 1) ? LOAD : WAIT;
      WAIT:  if (wait_cnt == WAIT_LAST) state_nxt = LOAD;
      LOAD:  state_nxt = drop_word ? FLUSH : HOLD;
      HOLD: begin
        if (ts_ack)        state_nxt = IDLE;
        else if (ts_flush) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = (q_cnt != 4'd0) ? REQ : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    q_rd_en_nxt = (state_nxt == REQ);
    valid_nxt   = ts_valid;
    data_nxt    = ts_data;
    pop_nxt     = ts_pop_cnt;
    drop_nxt    = ts_drop_cnt;
    pend_nxt    = flush_pend;
    busy_nxt    = ts_flush_busy;
    drop_inc    = 1'b0;
    case (state)
      REQ, WAIT: if (ts_flush) pend_nxt = 1'b1;
      LOAD: begin
        if (ts_flush) pend_nxt = 1'b1;
        if (drop_word) begin
          drop_inc = 1'b1;
        end else begin
          valid_nxt = 1'b1;
          data_nxt  = q_rd_data;
        end
      end
      HOLD: begin
        // Ack beats a same-cycle flush; the flush is remembered and run from IDLE.
        if (ts_ack) begin
          valid_nxt = 1'b0;
          pop_nxt   = ts_pop_cnt + 16'd1;
          if (ts_flush) pend_nxt = 1'b1;
        end else if (ts_flush) begin
          valid_nxt = 1'b0;
          drop_inc  = 1'b1;
        end
      end
      FLUSH: begin
        if (state_nxt == IDLE) begin
          pend_nxt = 1'b0;
          busy_nxt = 1'b0;
        end
      end
      default: ;
    endcase
    if (state_nxt == FLUSH) busy_nxt = 1'b1;
    if (drop_inc && (ts_drop_cnt != 8'hFF)) drop_nxt = ts_drop_cnt + 8'd1;
    pending_nxt = 8'(q_cnt) + 8'(ts_valid);
    irq_nxt     = (IRQ_THRESH != 0) && (ts_pending >= 8'(IRQ_THRESH));
  end

  always_ff @(posedge q_rd_clk) begin
    if (rst) begin
      q_rd_en       <= 1'b0;
      ts_valid      <= 1'b0;
      ts_data       <= 48'd0;
      ts_pending    <= 8'd0;
      ts_irq        <= 1'b0;
      ts_flush_busy <= 1'b0;
      ts_pop_cnt    <= 16'd0;
      ts_drop_cnt   <= 8'd0;
      flush_pend    <= 1'b0;
    end else begin
      q_rd_en       <= q_rd_en_nxt;
      ts_valid      <= valid_nxt;
      ts_data       <= data_nxt;
      ts_pending    <= pending_nxt;
      ts_irq        <= irq_nxt;
      ts_flush_busy <= busy_nxt;
      ts_pop_cnt    <= pop_nxt;
      ts_drop_cnt   <= drop_nxt;
      flush_pend    <= pend_nxt;
    end
  end

endmodule
